// File: rtl/seqgen_pkg.sv
// Shared types and helpers for the serial sequence generator.
package seqgen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  localparam logic [15:0] DEFAULT_PATTERN = 16'b0000_0000_0000_1011;
  localparam int          DEFAULT_LEN     = 4;

  function automatic logic len_ok(input logic [31:0] len, input logic [31:0] max_len);
    return (len != 32'd0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seqgen_shifter.sv
// Shadow pattern and MSB-first bit index; exposes the bit that will be on the
// line after the coming edge so the top can register it.
module seqgen_shifter #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               reload,
  input  logic               advance,
  input  logic [MAX_LEN-1:0] pattern_in,
  input  logic [LEN_W-1:0]   len_in,
  output logic               bit_nxt,
  output logic               last
);
  import seqgen_pkg::*;

  logic [MAX_LEN-1:0] shadow_q, shadow_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [MAX_LEN-1:0] shifted_s;

  // Next shadow/index: load wins over reload, reload over advance.
  always_comb begin
    shadow_d = shadow_q;
    len_d    = len_q;
    idx_d    = idx_q;
    if (load) begin
      shadow_d = pattern_in;
      len_d    = len_in;
      idx_d    = len_in - LEN_W'(1);
    end else if (reload) begin
      idx_d = len_q - LEN_W'(1);
    end else if (advance) begin
      idx_d = idx_q - LEN_W'(1);
    end else begin
      idx_d = idx_q;
    end
    shifted_s = shadow_d >> idx_d;
    bit_nxt   = shifted_s[0];
  end

  assign last = (idx_q == {LEN_W{1'b0}});

  // Shadow and index registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q <= {MAX_LEN{1'b0}};
      len_q    <= {LEN_W{1'b0}};
      idx_q    <= {LEN_W{1'b0}};
    end else begin
      shadow_q <= shadow_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
    end
  end

endmodule

// File: rtl/sequence_generator.sv
// Serial bit-pattern transmitter: sends a captured pattern MSB-first, repeated
// rpt times (0 = forever) with an optional idle gap, under ready backpressure.
module sequence_generator #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int RPT_W   = 8,
  parameter int GAP_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [RPT_W-1:0]   rpt,
  input  logic [GAP_W-1:0]   gap,
  input  logic               ready,
  output logic               x,
  output logic               x_valid,
  output logic               busy,
  output logic               done,
  output logic               err
);
  import seqgen_pkg::*;

  state_e             state_q, state_d;
  logic [RPT_W-1:0]   frames_q, frames_d;
  logic               cont_q, cont_d;
  logic [GAP_W-1:0]   gap_len_q, gap_len_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               x_q, x_d, x_valid_q, x_valid_d;
  logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic               load_s, reload_s, advance_s, bit_nxt_s, last_s;

  seqgen_shifter #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load       (load_s),
    .reload     (reload_s),
    .advance    (advance_s),
    .pattern_in (pattern),
    .len_in     (len),
    .bit_nxt    (bit_nxt_s),
    .last       (last_s)
  );

  // Next-state, counters, and the values the outputs take after the edge.
  always_comb begin
    state_d   = state_q;
    frames_d  = frames_q;
    cont_d    = cont_q;
    gap_len_d = gap_len_q;
    gap_cnt_d = gap_cnt_q;
    load_s    = 1'b0;
    reload_s  = 1'b0;
    advance_s = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len_ok(32'(len), 32'(MAX_LEN))) begin
            load_s    = 1'b1;
            state_d   = ST_SEND;
            frames_d  = rpt;
            cont_d    = (rpt == {RPT_W{1'b0}});
            gap_len_d = gap;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (ready) begin
          if (!last_s) begin
            advance_s = 1'b1;
          end else begin
            // Continuous mode never touches the frame counter.
            if (!cont_q) begin
              frames_d = frames_q - RPT_W'(1);
            end else begin
              frames_d = frames_q;
            end
            if (cont_q || (frames_q > RPT_W'(1))) begin
              if (gap_len_q == {GAP_W{1'b0}}) begin
                reload_s = 1'b1;
              end else begin
                state_d   = ST_GAP;
                gap_cnt_d = gap_len_q;
              end
            end else begin
              state_d = ST_FIN;
            end
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (gap_cnt_q <= GAP_W'(1)) begin
          reload_s  = 1'b1;
          state_d   = ST_SEND;
          gap_cnt_d = {GAP_W{1'b0}};
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    x_valid_d = (state_d == ST_SEND);
    x_d       = (state_d == ST_SEND) & bit_nxt_s;
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_FIN);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      frames_q  <= {RPT_W{1'b0}};
      cont_q    <= 1'b0;
      gap_len_q <= {GAP_W{1'b0}};
      gap_cnt_q <= {GAP_W{1'b0}};
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      frames_q  <= frames_d;
      cont_q    <= cont_d;
      gap_len_q <= gap_len_d;
      gap_cnt_q <= gap_cnt_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign x       = x_q;
  assign x_valid = x_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench: expected bits queued per scenario, compared on each transfer.
module tb_sequence_generator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] pattern = 16'd0;
  logic [4:0]  len = 5'd0;
  logic [7:0]  rpt = 8'd0;
  logic [3:0]  gap = 4'd0;
  logic        ready = 1'b1;
  logic        x, x_valid, busy, done, err;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   xfer_cnt = 0;
  logic exp_q[$];

  sequence_generator dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pattern(pattern),
    .len(len), .rpt(rpt), .gap(gap), .ready(ready),
    .x(x), .x_valid(x_valid), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pat(input logic [15:0] p, input int l, input int frames);
    logic [15:0] v;
    v = p;
    for (int f = 0; f < frames; f++)
      for (int b = l - 1; b >= 0; b--) exp_q.push_back(v[b]);
  endtask

  // Transfer monitor: each accepted bit is checked against the scoreboard.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (rst && x_valid && ready) begin
      xfer_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_xfer", 32'(x), 32'hDEAD);
      end else begin
        chk("xfer_bit", 32'(x), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int d0, t0;
    // Reset state
    tick(); tick();
    chk("rst_x", 32'(x), 0); chk("rst_xv", 32'(x_valid), 0);
    chk("rst_busy", 32'(busy), 0); chk("rst_done", 32'(done), 0); chk("rst_err", 32'(err), 0);
    rst = 1'b1;
    tick();

    // Single frame 1011
    pattern = 16'b1011; len = 5'd4; rpt = 8'd1; gap = 4'd0; ready = 1'b1;
    push_pat(16'b1011, 4, 1);
    d0 = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    chk("t1_c1_xv", 32'(x_valid), 1); chk("t1_c1_x", 32'(x), 1); chk("t1_c1_busy", 32'(busy), 1);
    for (int c = 2; c <= 4; c++) begin tick(); chk("t1_xv", 32'(x_valid), 1); end
    tick();
    chk("t1_c5_done", 32'(done), 1); chk("t1_c5_xv", 32'(x_valid), 0); chk("t1_c5_busy", 32'(busy), 1);
    tick();
    chk("t1_c6_busy", 32'(busy), 0); chk("t1_c6_done", 32'(done), 0);
    chk("t1_q_empty", 32'(exp_q.size()), 0); chk("t1_done_cnt", 32'(done_cnt - d0), 1);

    // Three frames with a two-cycle gap; inputs change after capture
    rpt = 8'd3; gap = 4'd2;
    push_pat(16'b1011, 4, 3);
    d0 = done_cnt; t0 = xfer_cnt;
    start = 1'b1; tick(); start = 1'b0;
    pattern = 16'h0000; len = 5'd0; rpt = 8'd0; gap = 4'd0;
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < 4; b++) begin chk("t2_xv_frame", 32'(x_valid), 1); tick(); end
      if (f < 2) begin
        chk("t2_gap1", 32'(x_valid), 0); chk("t2_gap1_busy", 32'(busy), 1); tick();
        chk("t2_gap2", 32'(x_valid), 0); tick();
      end
    end
    chk("t2_done", 32'(done), 1); tick();
    chk("t2_busy_end", 32'(busy), 0);
    chk("t2_xfers", 32'(xfer_cnt - t0), 12); chk("t2_done_cnt", 32'(done_cnt - d0), 1);

    // Backpressure in cycles 2-4
    pattern = 16'b1011; len = 5'd4; rpt = 8'd1; gap = 4'd0;
    push_pat(16'b1011, 4, 1);
    start = 1'b1; tick(); start = 1'b0;
    chk("t3_c1_x", 32'(x), 1); tick();
    ready = 1'b0;
    chk("t3_c2_x", 32'(x), 0); tick();
    chk("t3_c3_x", 32'(x), 0); chk("t3_c3_xv", 32'(x_valid), 1); tick();
    chk("t3_c4_x", 32'(x), 0); tick();
    ready = 1'b1;
    chk("t3_c5_x", 32'(x), 0); chk("t3_c5_done", 32'(done), 0); tick();
    chk("t3_c6_x", 32'(x), 1); tick();
    chk("t3_c7_x", 32'(x), 1); tick();
    chk("t3_c8_done", 32'(done), 1); tick();
    chk("t3_q_empty", 32'(exp_q.size()), 0);

    // Illegal lengths
    len = 5'd0; start = 1'b1; tick(); start = 1'b0;
    chk("t4_err0", 32'(err), 1); chk("t4_busy0", 32'(busy), 0); chk("t4_xv0", 32'(x_valid), 0);
    tick(); chk("t4_err0_pulse", 32'(err), 0);
    len = 5'd17; start = 1'b1; tick(); start = 1'b0;
    chk("t4_err17", 32'(err), 1); chk("t4_busy17", 32'(busy), 0); chk("t4_xv17", 32'(x_valid), 0);
    tick(); chk("t4_err17_pulse", 32'(err), 0);

    // Continuous 10 stream aborted in cycle 7
    pattern = 16'b10; len = 5'd2; rpt = 8'd0; gap = 4'd0;
    for (int i = 0; i < 7; i++) exp_q.push_back(i % 2 == 0);
    d0 = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 6; c++) begin chk("t5_xv", 32'(x_valid), 1); tick(); end
    abort = 1'b1;
    chk("t5_c7_xv", 32'(x_valid), 1); tick();
    abort = 1'b0;
    chk("t5_c8_xv", 32'(x_valid), 0); chk("t5_c8_busy", 32'(busy), 0); tick(); tick();
    chk("t5_no_done", 32'(done_cnt - d0), 0); chk("t5_q_empty", 32'(exp_q.size()), 0);

    // Asynchronous reset mid-frame, then a fresh transmission
    pattern = 16'b1011; len = 5'd4; rpt = 8'd1; gap = 4'd0;
    exp_q.push_back(1'b1);
    d0 = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    #1 rst = 1'b0;
    #1;
    chk("t6_rst_xv", 32'(x_valid), 0); chk("t6_rst_busy", 32'(busy), 0); chk("t6_rst_x", 32'(x), 0);
    tick();
    rst = 1'b1;
    tick();
    chk("t6_no_done", 32'(done_cnt - d0), 0); chk("t6_q_empty", 32'(exp_q.size()), 0);
    push_pat(16'b1011, 4, 1);
    start = 1'b1; tick(); start = 1'b0;
    chk("t6_restart_x", 32'(x), 1); chk("t6_restart_xv", 32'(x_valid), 1);
    for (int c = 0; c < 4; c++) tick();
    chk("t6_done", 32'(done), 1); tick();
    chk("t6_q_final", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
